// File: rtl/vc_arbiter_if.sv
// Handshake bundle between the VC FIFO read side, the arbiter and destination FIFOs D0/D1.
// The master modport is the arbiter; the slave modport is the surrounding FIFO environment.
interface vc_arbiter_if #(
    parameter int data_width = 6,
    parameter int cnt_width  = 5
);
    logic                  init;
    logic                  vc0_empty;
    logic                  vc1_empty;
    logic [data_width-1:0] vc0_head;
    logic [data_width-1:0] vc1_head;
    logic                  d0_almost_full;
    logic                  d1_almost_full;
    logic                  vc0_pop;
    logic                  vc1_pop;
    logic                  d0_push;
    logic                  d1_push;
    logic [data_width-1:0] d0_data;
    logic [data_width-1:0] d1_data;
    logic [cnt_width-1:0]  d0_count;
    logic [cnt_width-1:0]  d1_count;
    logic                  idle;

    modport master (
        input  init, vc0_empty, vc1_empty, vc0_head, vc1_head,
               d0_almost_full, d1_almost_full,
        output vc0_pop, vc1_pop, d0_push, d1_push, d0_data, d1_data,
               d0_count, d1_count, idle
    );

    modport slave (
        output init, vc0_empty, vc1_empty, vc0_head, vc1_head,
               d0_almost_full, d1_almost_full,
        input  vc0_pop, vc1_pop, d0_push, d1_push, d0_data, d1_data,
               d0_count, d1_count, idle
    );
endinterface

// File: rtl/vc_arbiter.sv
// Strict-priority VC0/VC1 FIFO reader that routes each popped word to D0 or D1 by its class bit.
// Pops are combinational from the look-ahead heads; pushes follow one cycle later.
module vc_arbiter #(
    parameter int data_width = 6,
    parameter int dest_bit   = 4,
    parameter int cnt_width  = 5
) (
    input logic          clk,
    input logic          reset,
    vc_arbiter_if.master bus
);
    localparam logic [1:0] ST_RESET  = 2'd0;
    localparam logic [1:0] ST_INIT   = 2'd1;
    localparam logic [1:0] ST_IDLE   = 2'd2;
    localparam logic [1:0] ST_ACTIVE = 2'd3;

    logic [1:0]            state;
    logic [1:0]            state_next;
    logic                  vc0_hold;
    logic                  vc1_hold;
    logic                  d0_push_q;
    logic                  d1_push_q;
    logic [data_width-1:0] d0_data_q;
    logic [data_width-1:0] d1_data_q;
    logic [cnt_width-1:0]  d0_count_q;
    logic [cnt_width-1:0]  d1_count_q;
    logic                  idle_q;

    logic                  arb_en;
    logic                  vc0_blocked;
    logic                  vc1_blocked;
    logic                  vc0_elig;
    logic                  vc1_elig;
    logic                  pop0;
    logic                  pop1;
    logic                  any_pop;
    logic [data_width-1:0] grant_word;
    logic                  grant_dest;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        arb_en      = reset && bus.init && (state == ST_IDLE || state == ST_ACTIVE);
        vc0_blocked = bus.vc0_head[dest_bit] ? bus.d1_almost_full : bus.d0_almost_full;
        vc1_blocked = bus.vc1_head[dest_bit] ? bus.d1_almost_full : bus.d0_almost_full;
        vc0_elig    = arb_en && !bus.vc0_empty && !vc0_hold && !vc0_blocked;
        vc1_elig    = arb_en && !bus.vc1_empty && !vc1_hold && !vc1_blocked;
        pop0        = vc0_elig;
        pop1        = vc1_elig && !vc0_elig;
        any_pop     = pop0 || pop1;
        grant_word  = pop0 ? bus.vc0_head : bus.vc1_head;
        grant_dest  = grant_word[dest_bit];
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_RESET: state_next = ST_INIT;
            ST_INIT:  if (bus.init) state_next = ST_IDLE;
            ST_IDLE: begin
                if (!bus.init)                            state_next = ST_INIT;
                else if (!bus.vc0_empty || !bus.vc1_empty) state_next = ST_ACTIVE;
            end
            default: begin
                // Stay active until both FIFOs are drained and nothing is still in flight.
                if (!bus.init)
                    state_next = ST_INIT;
                else if (bus.vc0_empty && bus.vc1_empty && !d0_push_q && !d1_push_q &&
                         !vc0_hold && !vc1_hold)
                    state_next = ST_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only; the data registers are
    // reset as well so the outputs never show X after reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_RESET;
            vc0_hold   <= 1'b0;
            vc1_hold   <= 1'b0;
            d0_push_q  <= 1'b0;
            d1_push_q  <= 1'b0;
            d0_data_q  <= '0;
            d1_data_q  <= '0;
            d0_count_q <= '0;
            d1_count_q <= '0;
            idle_q     <= 1'b0;
        end else begin
            state     <= state_next;
            idle_q    <= (state_next == ST_IDLE);
            // The FIFO head is stale for one cycle after a pop, so that VC sits out a cycle.
            vc0_hold  <= pop0;
            vc1_hold  <= pop1;
            d0_push_q <= any_pop && !grant_dest;
            d1_push_q <= any_pop && grant_dest;
            if (any_pop && !grant_dest) d0_data_q <= grant_word;
            if (any_pop && grant_dest)  d1_data_q <= grant_word;
            if (state == ST_RESET || state == ST_INIT) begin
                d0_count_q <= '0;
                d1_count_q <= '0;
            end else begin
                if (any_pop && !grant_dest) d0_count_q <= d0_count_q + {{(cnt_width-1){1'b0}}, 1'b1};
                if (any_pop && grant_dest)  d1_count_q <= d1_count_q + {{(cnt_width-1){1'b0}}, 1'b1};
            end
        end
    end

    assign bus.vc0_pop  = pop0;
    assign bus.vc1_pop  = pop1;
    assign bus.d0_push  = d0_push_q;
    assign bus.d1_push  = d1_push_q;
    assign bus.d0_data  = d0_data_q;
    assign bus.d1_data  = d1_data_q;
    assign bus.d0_count = d0_count_q;
    assign bus.d1_count = d1_count_q;
    assign bus.idle     = idle_q;
endmodule

// File: tb/tb_vc_arbiter.sv
// Self-checking bench for vc_arbiter: queue-backed VC FIFOs, a behavioural model of the
// arbitration rules, and a scoreboard monitor comparing every D0/D1 push.
module tb_vc_arbiter;
    localparam int DW = 6;
    localparam int CW = 5;
    localparam int DB = 4;

    typedef struct {
        logic [DW-1:0] word;
        int            due;
    } exp_t;

    typedef enum {M_RESET, M_INIT, M_IDLE, M_ACTIVE} mstate_t;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    vc_arbiter_if #(.data_width(DW), .cnt_width(CW)) bus ();

    vc_arbiter #(.data_width(DW), .dest_bit(DB), .cnt_width(CW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [DW-1:0] q0[$];
    logic [DW-1:0] q1[$];
    exp_t          exp0[$];
    exp_t          exp1[$];
    mstate_t       m_st     = M_RESET;
    int            last_pop = -1;
    int            m_cnt0   = 0;
    int            m_cnt1   = 0;
    int            cyc      = 0;
    int            checks   = 0;
    int            errors   = 0;
    logic          af0      = 1'b0;
    logic          af1      = 1'b0;
    logic          init_v   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    task automatic drive();
        bus.init           = init_v;
        bus.d0_almost_full = af0;
        bus.d1_almost_full = af1;
        bus.vc0_empty      = (q0.size() == 0);
        bus.vc1_empty      = (q1.size() == 0);
        bus.vc0_head       = (q0.size() > 0) ? q0[0] : '0;
        bus.vc1_head       = (q1.size() > 0) ? q1[0] : '0;
    endtask

    function automatic bit dest_full(input logic [DW-1:0] w);
        return w[DB] ? af1 : af0;
    endfunction

    task automatic model_reset();
        m_st     = M_RESET;
        last_pop = -1;
        m_cnt0   = 0;
        m_cnt1   = 0;
        exp0.delete();
        exp1.delete();
    endtask

    // One clock of the reference model: grant decided at the falling edge, state updated at the rising edge.
    task automatic step();
        int            g;
        logic [DW-1:0] w;
        mstate_t       prev;
        @(negedge clk);
        g = -1;
        if (reset && init_v && (m_st == M_IDLE || m_st == M_ACTIVE)) begin
            if (q0.size() > 0 && last_pop != 0 && !dest_full(q0[0]))      g = 0;
            else if (q1.size() > 0 && last_pop != 1 && !dest_full(q1[0])) g = 1;
        end
        check("vc0_pop", bus.vc0_pop, g == 0);
        check("vc1_pop", bus.vc1_pop, g == 1);
        check("idle", bus.idle, m_st == M_IDLE);
        check("d0_count", bus.d0_count, m_cnt0 % 32);
        check("d1_count", bus.d1_count, m_cnt1 % 32);
        if (g >= 0) begin
            w = (g == 0) ? q0[0] : q1[0];
            if (w[DB]) exp1.push_back('{w, cyc + 1});
            else       exp0.push_back('{w, cyc + 1});
        end
        @(posedge clk);
        cyc++;
        if (reset) begin
            prev = m_st;
            case (m_st)
                M_RESET: m_st = M_INIT;
                M_INIT:  if (init_v) m_st = M_IDLE;
                M_IDLE: begin
                    if (!init_v) m_st = M_INIT;
                    else if (q0.size() > 0 || q1.size() > 0) m_st = M_ACTIVE;
                end
                M_ACTIVE: begin
                    if (!init_v) m_st = M_INIT;
                    else if (q0.size() == 0 && q1.size() == 0 && last_pop == -1) m_st = M_IDLE;
                end
            endcase
            if (prev == M_RESET || prev == M_INIT) begin
                m_cnt0 = 0;
                m_cnt1 = 0;
            end else if (g >= 0) begin
                if (w[DB]) m_cnt1++;
                else       m_cnt0++;
            end
            if (g == 0)      void'(q0.pop_front());
            else if (g == 1) void'(q1.pop_front());
            last_pop = g;
        end
        #1;
        drive();
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic reinit();
        init_v = 1'b0;
        drive();
        step();
        init_v = 1'b1;
        drive();
        step();
    endtask

    // Scoreboard monitor: every push must match the oldest expectation due in this cycle.
    always @(negedge clk) begin
        if (bus.d0_push) begin
            if (exp0.size() == 0 || exp0[0].due != cyc) begin
                check("d0_push_unexpected", 1, 0);
            end else begin
                check("d0_data", bus.d0_data, exp0[0].word);
                void'(exp0.pop_front());
            end
        end
        if (bus.d1_push) begin
            if (exp1.size() == 0 || exp1[0].due != cyc) begin
                check("d1_push_unexpected", 1, 0);
            end else begin
                check("d1_data", bus.d1_data, exp1[0].word);
                void'(exp1.pop_front());
            end
        end
        while (exp0.size() > 0 && exp0[0].due < cyc) begin
            check("d0_push_missing", 0, 1);
            void'(exp0.pop_front());
        end
        while (exp1.size() > 0 && exp1[0].due < cyc) begin
            check("d1_push_missing", 0, 1);
            void'(exp1.pop_front());
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        drive();
        #1;
        check("rst_d0_push", bus.d0_push, 0);
        check("rst_d1_push", bus.d1_push, 0);
        check("rst_d0_data", bus.d0_data, 0);
        check("rst_d1_data", bus.d1_data, 0);
        check("rst_idle", bus.idle, 0);
        steps(2);

        reset = 1'b1;
        drive();
        for (int i = 0; i < 3; i++) begin
            step();
            check("init_d0_push", bus.d0_push, 0);
            check("init_idle", bus.idle, 0);
        end
        init_v = 1'b1;
        drive();
        step();
        check("idle_after_init", bus.idle, 1);

        q0.push_back(6'h05);
        drive();
        #1;
        check("single_vc0_pop", bus.vc0_pop, 1);
        step();
        check("single_d0_push", bus.d0_push, 1);
        check("single_d0_data", bus.d0_data, 6'h05);
        check("single_d0_count", bus.d0_count, 1);
        check("single_d1_push", bus.d1_push, 0);
        steps(3);

        reinit();
        check("reinit_d0_count", bus.d0_count, 0);
        for (int i = 0; i < 3; i++) begin
            q0.push_back(DW'($urandom) & 6'h2f);
            q1.push_back(DW'($urandom) | 6'h10);
        end
        drive();
        for (int i = 0; i < 6; i++) begin
            #1;
            check("alt_vc0_pop", bus.vc0_pop, (i % 2) == 0);
            check("alt_vc1_pop", bus.vc1_pop, (i % 2) == 1);
            step();
        end
        check("alt_d0_count", bus.d0_count, 3);
        check("alt_d1_count", bus.d1_count, 3);
        steps(2);

        af0 = 1'b1;
        q0.push_back(6'h02);
        q1.push_back(6'h13);
        drive();
        #1;
        check("bp_vc0_pop", bus.vc0_pop, 0);
        check("bp_vc1_pop", bus.vc1_pop, 1);
        step();
        check("bp_d1_push", bus.d1_push, 1);
        check("bp_d1_data", bus.d1_data, 6'h13);
        check("bp_d0_push", bus.d0_push, 0);
        af0 = 1'b0;
        drive();
        steps(4);

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 1) == 1 && q0.size() < 6) q0.push_back(DW'($urandom));
            if ($urandom_range(0, 1) == 1 && q1.size() < 6) q1.push_back(DW'($urandom));
            af0 = ($urandom_range(0, 3) == 0);
            af1 = ($urandom_range(0, 3) == 0);
            drive();
            step();
        end
        af0 = 1'b0;
        af1 = 1'b0;
        drive();
        steps(40);
        check("random_q0_drained", q0.size(), 0);
        check("random_q1_drained", q1.size(), 0);

        reinit();
        for (int i = 0; i < 33; i++) q1.push_back(DW'($urandom) | 6'h10);
        drive();
        steps(70);
        check("wrap_d1_count", bus.d1_count, 1);
        check("wrap_d0_count", bus.d0_count, 0);

        q0.push_back(DW'($urandom) & 6'h2f);
        drive();
        found = 1'b0;
        for (int i = 0; i < 4 && !found; i++) begin
            step();
            if (bus.d0_push) found = 1'b1;
        end
        check("mid_push_seen", found, 1);
        #2;
        reset  = 1'b0;
        init_v = 1'b0;
        q0.push_back(6'h07);
        drive();
        #1;
        check("async_d0_push", bus.d0_push, 0);
        check("async_d1_push", bus.d1_push, 0);
        check("async_d0_count", bus.d0_count, 0);
        check("async_d1_count", bus.d1_count, 0);
        check("async_vc0_pop", bus.vc0_pop, 0);
        model_reset();
        steps(2);
        reset = 1'b1;
        drive();
        steps(2);
        #1;
        check("requal_vc0_pop", bus.vc0_pop, 0);
        init_v = 1'b1;
        drive();
        steps(6);
        check("requal_q0_drained", q0.size(), 0);
        check("requal_d0_count", bus.d0_count, 1);

        steps(2);
        check("exp0_drained", exp0.size(), 0);
        check("exp1_drained", exp1.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
